serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 90 +++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor: one full-subtractor cell with a registered borrow,
// LSB first, parallel load on start and parallel result with a done pulse.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CNT_W-1:0] cnt;

   logic             d_c;
   logic             br_next_c;
   logic [WIDTH-1:0] res_next_c;

   // Full-subtractor cell on the current LSBs and the carried borrow
   assign d_c        = sa[0] ^ sb[0] ^ br;
   assign br_next_c  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
   assign res_next_c = {d_c, res[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         res   <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
               res <= res_next_c;
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next_c;
               if (cnt == LAST_BIT) begin
                  diff  <= res_next_c;
                  bout  <= br_next_c;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, random operands,
// back-to-back, ignored start, mid-run reset, and an exhaustive 4-bit sweep.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       bout;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       busy4;
   logic       done4;
   logic [3:0] diff4;
   logic       bout4;

   int total;
   int bad;

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .bout(bout)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: a + ~b + 1 in w+1 bits; borrow is the inverted carry out
   function automatic int ref_sub(int w, int x, int y);
      int mask;
      int s;
      mask = (1 << w) - 1;
      s    = (x & mask) + ((~y) & mask) + 1;
      return ((1 - ((s >> w) & 1)) << w) | (s & mask);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Drive a one-cycle start; returns at the negedge just after the accepting edge
   task automatic start_op(input logic [7:0] aa, input logic [7:0] bb);
      @(negedge clk);
      a     = aa;
      b     = bb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
   endtask

   // Waits for done; counts cycles, busy cycles and changes of the held result
   task automatic wait_done(input logic [8:0] held, output int lat, output int busy_n,
                            output int hold_bad);
      lat      = 0;
      busy_n   = 0;
      hold_bad = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) busy_n++;
         if ({bout, diff} !== held) hold_bad++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_and_check(input string tag, input logic [7:0] aa, input logic [7:0] bb);
      int lat, bn, hb;
      logic [8:0] held;
      held = {bout, diff};
      start_op(aa, bb);
      wait_done(held, lat, bn, hb);
      check({tag, " latency"}, 32'(lat), 32'd8);
      check({tag, " busy cycles"}, 32'(bn), 32'd8);
      check({tag, " hold during run"}, 32'(hb), 32'd0);
      check({tag, " result"}, 32'({bout, diff}), 32'(ref_sub(8, int'(aa), int'(bb))));
      check({tag, " busy in done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int lat, bn, hb, cnt_done;
      logic [8:0] held;
      logic [7:0] ra, rb;

      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      start4 = 1'b0;
      a4     = '0;
      b4     = '0;

      repeat (2) @(negedge clk);
      check("reset outputs", 32'({busy, done, bout, diff}), 32'd0);
      rst_n = 1'b1;

      // Directed cases
      run_and_check("200-55", 8'd200, 8'd55);
      check("200-55 diff", 32'(diff), 32'd145);
      @(negedge clk);
      check("done single pulse", 32'(done), 32'd0);
      run_and_check("5-10", 8'd5, 8'd10);
      check("5-10 value", 32'({bout, diff}), 32'h1FB);
      run_and_check("0-255", 8'd0, 8'd255);
      check("0-255 value", 32'({bout, diff}), 32'h101);
      run_and_check("A5-A5", 8'hA5, 8'hA5);
      check("A5-A5 value", 32'({bout, diff}), 32'h000);

      // Second start 3 cycles into RUN is ignored
      held = {bout, diff};
      start_op(8'd77, 8'd30);
      repeat (2) @(negedge clk);
      a = 8'd3; b = 8'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(held, lat, bn, hb);
      check("ignored start latency", 32'(lat), 32'd5);
      check("ignored start result", 32'({bout, diff}), 32'(ref_sub(8, 77, 30)));
      cnt_done = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) cnt_done++;
      end
      check("no extra done", 32'(cnt_done), 32'd0);

      // Start in the done cycle: second done 9 cycles after the first
      start_op(8'd50, 8'd20);
      wait_done(held, lat, bn, hb);
      check("b2b first result", 32'({bout, diff}), 32'd30);
      held = {bout, diff};
      a = 8'd100; b = 8'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(held, lat, bn, hb);
      check("b2b spacing", 32'(lat + 1), 32'd9);
      check("b2b first held", 32'(hb), 32'd0);
      check("b2b second result", 32'({bout, diff}), 32'd99);

      // Asynchronous reset mid-run aborts the operation
      start_op(8'd9, 8'd3);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("mid-run reset outputs", 32'({busy, done, bout, diff}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cnt_done = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) cnt_done++;
      end
      check("no done after abort", 32'(cnt_done), 32'd0);
      run_and_check("9-3 after reset", 8'd9, 8'd3);
      check("9-3 diff", 32'(diff), 32'd6);

      // Random operands
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
         run_and_check("random", ra, rb);
      end

      // Exhaustive 4-bit sweep
      for (int i = 0; i < 256; i++) begin
         int n;
         @(negedge clk);
         a4     = 4'(i >> 4);
         b4     = 4'(i);
         start4 = 1'b1;
         @(negedge clk);
         start4 = 1'b0;
         n = 0;
         while (done4 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("w4 latency", 32'(n), 32'd4);
         check("w4 result", 32'({bout4, diff4}), 32'(ref_sub(4, i >> 4, i & 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
